// File: rtl/result_buffer.sv
// Result FIFO between the accelerator and its consumer, with batch
// tracking driven by the accelerator's completion flag.
module result_buffer #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrReq,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wDone,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              batchDone,
  output logic [7:0]        batchCount
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                batch_done_q, batch_done_d;
  logic [7:0]          batch_count_q, batch_count_d;
  logic                wdone_prev_q, wdone_prev_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic rd_acc;
  logic wr_acc;
  logic wdone_rise;

  // A write into a full FIFO is only legal if a read frees a slot now.
  assign rd_acc     = rdEn & ~empty_q;
  assign wr_acc     = wrReq & (~full_q | rd_acc);
  assign wdone_rise = wDone & ~wdone_prev_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_acc;
    overflow_d    = overflow_q | (wrReq & ~wr_acc);
    wdone_prev_d  = wDone;
    state_d       = state_q;
    batch_done_d  = 1'b0;
    batch_count_d = batch_count_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end

    unique case (1'b1)
      (wr_acc & ~rd_acc): count_d = count_q + 1'b1;
      (rd_acc & ~wr_acc): count_d = count_q - 1'b1;
      default:            count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == (AW + 1)'(DEPTH));

    unique case (state_q)
      IDLE: begin
        if (wdone_rise) begin
          state_d = DRAIN;
        end else if (wr_acc) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (wdone_rise) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d       = IDLE;
          batch_done_d  = 1'b1;
          batch_count_d = batch_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      batch_done_q  <= 1'b0;
      batch_count_q <= '0;
      wdone_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      batch_done_q  <= batch_done_d;
      batch_count_q <= batch_count_d;
      wdone_prev_q  <= wdone_prev_d;
    end
  end

  // Storage is not reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem_q[wr_ptr_q] <= wrData;
    end
  end

  assign rdData     = rd_data_q;
  assign rdValid    = rd_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign batchDone  = batch_done_q;
  assign batchCount = batch_count_q;

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer: queue-based reference model checked
// every cycle, plus literal expectations at key points.
module tb_result_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrReq = 1'b0;
  logic [20:0] wrData = '0;
  logic        wDone = 1'b0;
  logic        rdEn = 1'b0;
  logic [20:0] rdData;
  logic        rdValid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        batchDone;
  logic [7:0]  batchCount;

  int vecs = 0;
  int errs = 0;
  int pulses = 0;

  // reference model state
  logic [20:0] mq[$];
  logic [20:0] m_rd = '0;
  logic        m_vld = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_prev = 1'b0;
  logic        m_bdone = 1'b0;
  logic [7:0]  m_bc = '0;
  logic        started = 1'b0;

  result_buffer #(.DATA_W(21), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .wrReq(wrReq), .wrData(wrData),
    .wDone(wDone), .rdEn(rdEn), .rdData(rdData), .rdValid(rdValid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .batchDone(batchDone), .batchCount(batchCount)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_rd = '0; m_vld = 0; m_ovf = 0; m_drain = 0;
      m_prev = 0; m_bdone = 0; m_bc = '0;
      started = 1'b1;
    end else if (started) begin
      automatic bit rd = rdEn && (mq.size() > 0);
      automatic bit wr = wrReq && ((mq.size() < 8) || rd);
      if (wrReq && !wr) m_ovf = 1'b1;
      m_bdone = 1'b0;
      if (m_drain && mq.size() == 0) begin
        m_drain = 1'b0;
        m_bdone = 1'b1;
        m_bc = m_bc + 8'd1;
      end else if (!m_drain && wDone && !m_prev) begin
        m_drain = 1'b1;
      end
      m_prev = wDone;
      m_vld = rd;
      if (rd) m_rd = mq.pop_front();
      if (wr) mq.push_back(wrData);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdData", 32'(rdData), 32'(m_rd));
      chk("rdValid", 32'(rdValid), 32'(m_vld));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 8));
      chk("count", 32'(count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("batchDone", 32'(batchDone), 32'(m_bdone));
      chk("batchCount", 32'(batchCount), 32'(m_bc));
    end
  end

  task automatic step(input logic r, input logic w, input logic [20:0] d,
                      input logic wd, input logic re);
    rst = r; wrReq = w; wrData = d; wDone = wd; rdEn = re;
    @(negedge clk);
    if (batchDone === 1'b1) pulses++;
  endtask

  task automatic wr(input logic [20:0] d);
    step(1, 1, d, 0, 0);
  endtask

  task automatic rd();
    step(1, 0, '0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, 0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdValid", 32'(rdValid), 32'd0);

    wr(21'h120E5);
    wr(21'h10F7A);
    rd();
    chk("t1_rd0", 32'(rdData), 32'h120E5);
    chk("t1_v0", 32'(rdValid), 32'd1);
    rd();
    chk("t1_rd1", 32'(rdData), 32'h10F7A);
    chk("t1_v1", 32'(rdValid), 32'd1);
    chk("t1_empty", 32'(empty), 32'd1);
    rd();
    chk("t1_hold", 32'(rdData), 32'h10F7A);
    chk("t1_nv", 32'(rdValid), 32'd0);

    for (int i = 1; i <= 9; i++) begin
      wr(21'(i));
      if (i == 8) begin
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_cnt", 32'(count), 32'd8);
        chk("t2_ovf0", 32'(overflow), 32'd0);
      end
    end
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk("t2_rd", 32'(rdData), 32'(i));
    end
    chk("t2_empty", 32'(empty), 32'd1);

    do_reset();
    for (int i = 1; i <= 8; i++) wr(21'(i));
    step(1, 1, 21'h1FFFF, 0, 1);
    chk("t3_cnt", 32'(count), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_rd", 32'(rdData), 32'd1);
    for (int i = 0; i < 8; i++) rd();
    chk("t3_last", 32'(rdData), 32'h1FFFF);
    chk("t3_empty", 32'(empty), 32'd1);

    do_reset();
    wr(21'h0AAAA);
    wr(21'h15555);
    wr(21'h00F0F);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, '0, 1, (k >= 1 && k <= 3));
      if (k == 3) chk("t4_pre", 32'(batchDone), 32'd0);
      if (k == 4) chk("t4_pulse", 32'(batchDone), 32'd1);
    end
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_bc", 32'(batchCount), 32'd1);

    for (int i = 0; i < 4; i++) wr(21'(i + 32));
    chk("t5_cnt4", 32'(count), 32'd4);
    step(0, 1, 21'h5, 1, 1);
    chk("t5_cnt", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_bc", 32'(batchCount), 32'd0);
    rd();
    chk("t5_nv", 32'(rdValid), 32'd0);
    chk("t5_rd", 32'(rdData), 32'd0);

    do_reset();
    pulses = 0;
    wr(21'h00123);
    for (int b = 0; b < 256; b++) begin
      step(1, 0, '0, 1, (b == 0));
      step(1, 0, '0, 0, 0);
      if (b == 0) step(1, 0, '0, 0, 0);
      if (b == 254) chk("t6_255", 32'(batchCount), 32'd255);
    end
    chk("t6_wrap", 32'(batchCount), 32'd0);
    chk("t6_pulses", 32'(pulses), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 Parameter DATA_W, default 21, is the result word width and matches the accelerator wrData width.
REQ-002 Parameter DEPTH, default 8, is the FIFO entry count; it SHALL be a power of two.
REQ-003 Parameter AW, default 3, is the pointer width, equal to log2(DEPTH).
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the reset: synchronous, active-low, one clock, sampled on the rising edge of clk.
REQ-006 Port wrReq, input, 1, is the accelerator write strobe; each high cycle carries one result word.
REQ-007 Port wrData, input, DATA_W, is the result word, valid when wrReq=1.
REQ-008 Port wDone, input, 1, is the accelerator completion flag; it is a level or a pulse.
REQ-009 Port rdEn, input, 1, is the consumer read request.
REQ-010 Port rdData, output, DATA_W, is the registered read word.
REQ-011 Port rdValid, output, 1, is a one-cycle qualifier for rdData.
REQ-012 Ports empty and full, outputs, 1 each, are the FIFO status flags.
REQ-013 Port count, output, AW+1, is the occupancy in the range 0..DEPTH.
REQ-014 Port overflow, output, 1, is a sticky dropped-write flag.
REQ-015 Port batchDone, output, 1, is a one-cycle end-of-batch pulse.
REQ-016 Port batchCount, output, 8, is the number of completed batches.

Function
REQ-017 A write SHALL be accepted when wrReq=1 and either full=0, or full=1 with a read accepted in the same cycle: store at wrPtr, then wrPtr+1 mod DEPTH.
REQ-018 wrReq=1 with full=1 and no accepted read SHALL leave the FIFO unchanged and set overflow=1, which holds until reset.
REQ-019 A read SHALL be accepted when rdEn=1 and empty=0.
- Next cycle: rdData = mem[rdPtr] and rdValid=1.
- rdPtr advances mod DEPTH.
REQ-020 rdEn=1 with empty=1 SHALL be ignored: rdValid=0 next cycle and rdData holds its previous value.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged; when empty=1 only the write occurs (no bypass).
REQ-022 count, empty (count==0) and full (count==DEPTH) SHALL be registered and consistent in the same cycle.
REQ-023 Edge detect: a wDone rising edge is wDone=1 in the current cycle and wDone=0 in the previous registered cycle.
REQ-024 FSM states: IDLE, COLLECT, DRAIN.
- IDLE->COLLECT on an accepted write.
- IDLE or COLLECT -> DRAIN on a wDone rising edge.
- DRAIN->IDLE in the first cycle with count==0.
REQ-025 A wDone rising edge in IDLE with an empty FIFO SHALL still pass through DRAIN (one cycle) so every batch produces a pulse.
REQ-026 On the DRAIN->IDLE transition:
- batchDone SHALL be 1 for exactly that cycle.
- batchCount SHALL increment, wrapping 255->0.
REQ-027 Writes during DRAIN SHALL be accepted normally; DRAIN exits only at count==0.
REQ-028 A wDone rising edge while already in DRAIN SHALL be ignored.

Reset
REQ-029 While rst=0 at a clock edge, all of the following SHALL be cleared:
- wrPtr=0, rdPtr=0, count=0, empty=1, full=0.
- overflow=0, rdValid=0, rdData=0.
- batchDone=0, batchCount=0, state=IDLE, previous-wDone register=0.
REQ-030 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-031 Inputs during reset cycles SHALL be ignored.

Verification
REQ-032 Reset, then write 0x120E5 and then 0x10F7A, then rdEn for 2 cycles -> rdData 0x120E5 then 0x10F7A on consecutive cycles with rdValid=1, empty=1 afterwards.
REQ-033 Write 9 words 0x00001..0x00009 with no reads -> full=1 and count=8 after the 8th write, overflow=1 after the 9th, and reads return 0x00001..0x00008.
REQ-034 At full, wrReq=1 and rdEn=1 in the same cycle with data 0x1FFFF -> count stays 8, overflow=0, and 0x1FFFF is read last.
REQ-035 Write 3 words, pulse wDone, then read all 3 -> state goes to DRAIN, batchDone=1 in exactly one cycle after the 3rd read, batchCount=1; holding wDone high for 10 cycles produces no second pulse.
REQ-036 Write 4 words, drive rst=0 for 1 cycle -> count=0, empty=1, and batchCount=0; a following read request gives rdValid=0.
REQ-037 Complete 256 batches -> batchCount wraps to 0.
